// File: rtl/dmem_bus_if_pkg.sv
// Shared types and constants for the data-side Wishbone bridge.
package dmem_bus_if_pkg;

  typedef enum logic [1:0] {
    DBUS_IDLE       = 2'b00,
    DBUS_BUSY       = 2'b01,
    DBUS_WAIT_STALL = 2'b10
  } dbus_state_e;

  localparam logic        RST_ENABLE   = 1'b0;
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        WRITE_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_bus_if.sv
// MEM-stage to Wishbone-classic bridge: read data returned in the ack cycle, stallreq_o held
// until ack/abort; returned data is parked while stall_i[STALL_IDX] freezes the MEM stage.
module dmem_bus_if
  import dmem_bus_if_pkg::*;
#(
  parameter int STALL_IDX   = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        bus_err_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  dbus_state_e state_q, state_d;

  logic [31:0]      adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic             we_q, we_d;
  logic [3:0]       sel_q, sel_d;
  logic             stb_q, stb_d;
  logic             cyc_q, cyc_d;
  logic [31:0]      rd_buf_q, rd_buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;

  logic req_start;
  logic mem_frozen;
  logic timeout_hit;
  logic unused_inputs;

  assign req_start   = (cpu_ce_i == CHIP_ENABLE) && !flush_i;
  assign mem_frozen  = stall_i[STALL_IDX];
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Only one stall bit matters here and the bus is word addressed.
  assign unused_inputs = ^{stall_i, cpu_addr_i[1:0]};

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q   <= DBUS_IDLE;
      adr_q     <= ZERO_WORD;
      dat_q     <= ZERO_WORD;
      we_q      <= 1'b0;
      sel_q     <= 4'b0000;
      stb_q     <= 1'b0;
      cyc_q     <= 1'b0;
      rd_buf_q  <= ZERO_WORD;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      stb_q     <= stb_d;
      cyc_q     <= cyc_d;
      rd_buf_q  <= rd_buf_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    sel_d     = sel_q;
    stb_d     = stb_q;
    cyc_d     = cyc_q;
    rd_buf_d  = rd_buf_q;
    cnt_d     = cnt_q;
    bus_err_d = 1'b0;
    case (state_q)
      DBUS_IDLE: begin
        if (req_start) begin
          adr_d   = word_align(cpu_addr_i);
          dat_d   = cpu_data_i;
          we_d    = (cpu_we_i == WRITE_ENABLE);
          sel_d   = cpu_sel_i;
          stb_d   = 1'b1;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = DBUS_BUSY;
        end
      end
      DBUS_BUSY: begin
        // Flush beats ack beats timeout.
        if (flush_i) begin
          stb_d    = 1'b0;
          cyc_d    = 1'b0;
          rd_buf_d = ZERO_WORD;
          state_d  = DBUS_IDLE;
        end else if (wb_ack_i) begin
          stb_d    = 1'b0;
          cyc_d    = 1'b0;
          rd_buf_d = wb_dat_i;
          state_d  = mem_frozen ? DBUS_WAIT_STALL : DBUS_IDLE;
        end else if (timeout_hit) begin
          stb_d     = 1'b0;
          cyc_d     = 1'b0;
          rd_buf_d  = ZERO_WORD;
          bus_err_d = 1'b1;
          state_d   = mem_frozen ? DBUS_WAIT_STALL : DBUS_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DBUS_WAIT_STALL: begin
        if (flush_i) begin
          rd_buf_d = ZERO_WORD;
          state_d  = DBUS_IDLE;
        end else if (!mem_frozen) begin
          state_d = DBUS_IDLE;
        end
      end
      default: begin
        stb_d   = 1'b0;
        cyc_d   = 1'b0;
        state_d = DBUS_IDLE;
      end
    endcase
  end

  // The ack cycle releases the pipeline directly with bus data, saving a cycle of stall.
  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = ZERO_WORD;
    if (rst != RST_ENABLE) begin
      case (state_q)
        DBUS_IDLE: stallreq_o = req_start;
        DBUS_BUSY: begin
          if (!flush_i) begin
            if (wb_ack_i) begin
              cpu_data_o = wb_dat_i;
            end else if (!timeout_hit) begin
              stallreq_o = 1'b1;
            end
          end
        end
        DBUS_WAIT_STALL: cpu_data_o = rd_buf_q;
        default: begin
          stallreq_o = 1'b0;
          cpu_data_o = ZERO_WORD;
        end
      endcase
    end
  end

  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_we_o   = we_q;
  assign wb_sel_o  = sel_q;
  assign wb_stb_o  = stb_q;
  assign wb_cyc_o  = cyc_q;
  assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_dmem_bus_if.sv
// Bench for dmem_bus_if: directed vector table, corner-case sequences, then random traffic
// checked every cycle against a transaction-level reference model.
module tb_dmem_bus_if;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        cpu_ce_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        bus_err_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  always #5 clk = ~clk;

  dmem_bus_if #(.STALL_IDX(4), .TIMEOUT_CYC(T), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .bus_err_o(bus_err_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: an outstanding access with its age, plus a parked result.
  bit          m_pending = 0;
  bit          m_parked  = 0;
  bit          m_err     = 0;
  int          m_age     = 0;
  logic [31:0] m_buf = '0, m_adr = '0, m_dat = '0;
  logic        m_we  = 1'b0;
  logic [3:0]  m_sel = '0;

  typedef struct {
    bit rst; bit stl; bit fl; bit ce; bit we;
    logic [31:0] addr; logic [3:0] sel; logic [31:0] dat; logic [31:0] rdat; bit ack;
    bit e_stall; logic [31:0] e_data; bit e_cyc; bit e_err;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic        e_stall;
    logic [31:0] e_data;
    e_stall = 1'b0;
    e_data  = '0;
    if (rst) begin
      if (m_parked) e_data = m_buf;
      else if (m_pending) begin
        if (!flush_i) begin
          if (wb_ack_i) e_data = wb_dat_i;
          else if (m_age != T - 1) e_stall = 1'b1;
        end
      end else e_stall = cpu_ce_i && !flush_i;
    end
    chk("m_stallreq", {31'b0, stallreq_o}, {31'b0, e_stall});
    chk("m_cpu_data", cpu_data_o, e_data);
    chk("m_wb_cyc", {31'b0, wb_cyc_o}, {31'b0, m_pending});
    chk("m_wb_stb", {31'b0, wb_stb_o}, {31'b0, m_pending});
    chk("m_bus_err", {31'b0, bus_err_o}, {31'b0, m_err});
    chk("m_wb_adr", wb_adr_o, m_adr);
    chk("m_wb_dat", wb_dat_o, m_dat);
    chk("m_wb_we", {31'b0, wb_we_o}, {31'b0, m_we});
    chk("m_wb_sel", {28'b0, wb_sel_o}, {28'b0, m_sel});
  endtask

  task automatic model_update();
    bit err_n;
    err_n = 0;
    if (!rst) begin
      m_pending = 0; m_parked = 0; m_age = 0;
      m_buf = '0; m_adr = '0; m_dat = '0; m_we = 1'b0; m_sel = '0;
    end else if (m_parked) begin
      if (!stall_i[4] || flush_i) begin
        m_parked = 0;
        if (flush_i) m_buf = '0;
      end
    end else if (m_pending) begin
      if (flush_i) begin
        m_pending = 0; m_buf = '0;
      end else if (wb_ack_i || m_age == T - 1) begin
        m_pending = 0;
        m_buf     = wb_ack_i ? wb_dat_i : 32'h0;
        err_n     = !wb_ack_i;
        m_parked  = stall_i[4];
      end else m_age++;
    end else if (cpu_ce_i && !flush_i) begin
      m_pending = 1; m_age = 0;
      m_adr = cpu_addr_i & 32'hFFFF_FFFC;
      m_dat = cpu_data_i; m_we = cpu_we_i; m_sel = cpu_sel_i;
    end
    m_err = err_n;
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic at_pos();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    at_neg();
    at_pos();
  endtask

  task automatic drive(input bit r, input bit stl, input bit fl, input bit ce, input bit we,
                       input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] dat,
                       input logic [31:0] rdat, input bit ack);
    rst = r; stall_i = {1'b0, stl, 4'b0000}; flush_i = fl; cpu_ce_i = ce; cpu_we_i = we;
    cpu_addr_i = addr; cpu_sel_i = sel; cpu_data_i = dat; wb_dat_i = rdat; wb_ack_i = ack;
  endtask

  initial begin
    //            rst stl fl ce we addr          sel   dat           rdat          ack  stall data          cyc err
    tbl[0]  = '{1'b0,0,0,0,0, 32'h0,   4'h0, 32'h0,        32'h0,        0,   0, 32'h0,        0, 0};
    tbl[1]  = '{1'b1,0,0,1,0, 32'h104, 4'hF, 32'h0,        32'h0,        0,   1, 32'h0,        0, 0};
    tbl[2]  = '{1'b1,0,0,1,0, 32'h104, 4'hF, 32'h0,        32'h0,        0,   1, 32'h0,        1, 0};
    tbl[3]  = '{1'b1,0,0,1,0, 32'h104, 4'hF, 32'h0,        32'h0,        0,   1, 32'h0,        1, 0};
    tbl[4]  = '{1'b1,0,0,1,0, 32'h104, 4'hF, 32'h0,        32'h0,        0,   1, 32'h0,        1, 0};
    tbl[5]  = '{1'b1,0,0,1,0, 32'h104, 4'hF, 32'h0,        32'hDEADBEEF, 1,   0, 32'hDEADBEEF, 1, 0};
    tbl[6]  = '{1'b1,0,0,0,0, 32'h0,   4'h0, 32'h0,        32'h0,        0,   0, 32'h0,        0, 0};
    tbl[7]  = '{1'b1,0,0,1,1, 32'h202, 4'h3, 32'h0000A5A5, 32'h0,        0,   1, 32'h0,        0, 0};
    tbl[8]  = '{1'b1,0,0,1,1, 32'h202, 4'h3, 32'h0000A5A5, 32'h0,        0,   1, 32'h0,        1, 0};
    tbl[9]  = '{1'b1,0,0,1,1, 32'h202, 4'h3, 32'h0000A5A5, 32'h0,        1,   0, 32'h0,        1, 0};
    tbl[10] = '{1'b1,0,0,0,0, 32'h0,   4'h0, 32'h0,        32'h0,        0,   0, 32'h0,        0, 0};
    tbl[11] = '{1'b1,0,0,1,0, 32'h300, 4'hF, 32'h0,        32'h0,        0,   1, 32'h0,        0, 0};
    tbl[12] = '{1'b1,0,0,1,0, 32'h300, 4'hF, 32'h0,        32'h0,        0,   1, 32'h0,        1, 0};
    tbl[13] = '{1'b1,0,0,1,0, 32'h300, 4'hF, 32'h0,        32'h0,        0,   1, 32'h0,        1, 0};
    tbl[14] = '{1'b1,0,0,1,0, 32'h300, 4'hF, 32'h0,        32'h0,        0,   1, 32'h0,        1, 0};
    tbl[15] = '{1'b1,0,0,1,0, 32'h300, 4'hF, 32'h0,        32'h0,        0,   0, 32'h0,        1, 0};
    tbl[16] = '{1'b1,0,0,0,0, 32'h0,   4'h0, 32'h0,        32'h0,        0,   0, 32'h0,        0, 1};
    tbl[17] = '{1'b1,0,0,0,0, 32'h0,   4'h0, 32'h0,        32'h0,        0,   0, 32'h0,        0, 0};

    drive(0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst, tbl[i].stl, tbl[i].fl, tbl[i].ce, tbl[i].we, tbl[i].addr,
            tbl[i].sel, tbl[i].dat, tbl[i].rdat, tbl[i].ack);
      at_neg();
      chk($sformatf("v%0d_stallreq", i), {31'b0, stallreq_o}, {31'b0, tbl[i].e_stall});
      chk($sformatf("v%0d_cpu_data", i), cpu_data_o, tbl[i].e_data);
      chk($sformatf("v%0d_wb_cyc", i), {31'b0, wb_cyc_o}, {31'b0, tbl[i].e_cyc});
      chk($sformatf("v%0d_bus_err", i), {31'b0, bus_err_o}, {31'b0, tbl[i].e_err});
      if (i == 3)  chk("read_adr", wb_adr_o, 32'h104);
      if (i == 8)  chk("write_dat", wb_dat_o, 32'h0000A5A5);
      if (i == 8)  chk("write_sel_we", {27'b0, wb_sel_o, wb_we_o}, {27'b0, 4'b0011, 1'b1});
      if (i == 8)  chk("write_adr_aligned", wb_adr_o, 32'h200);
      at_pos();
    end

    // Ack while MEM is frozen: result parked until stall_i[4] drops.
    drive(1, 0, 0, 1, 0, 32'h400, 4'hF, 32'h0, 32'h0, 0);
    cycle();
    cycle();
    drive(1, 1, 0, 1, 0, 32'h400, 4'hF, 32'h0, 32'h12345678, 1);
    at_neg();
    chk("held_ack_data", cpu_data_o, 32'h12345678);
    at_pos();
    drive(1, 1, 0, 1, 0, 32'h400, 4'hF, 32'h0, 32'h0, 0);
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("held_data", cpu_data_o, 32'h12345678);
      chk("held_stallreq", {31'b0, stallreq_o}, 32'h0);
      chk("held_cyc", {31'b0, wb_cyc_o}, 32'h0);
      at_pos();
    end
    drive(1, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 0);
    at_neg();
    chk("held_release_data", cpu_data_o, 32'h12345678);
    at_pos();
    at_neg();
    chk("held_after_data", cpu_data_o, 32'h0);
    at_pos();

    // Flush and ack in the same cycle: flush wins, later stray ack ignored.
    drive(1, 0, 0, 1, 0, 32'h500, 4'hF, 32'h0, 32'h0, 0);
    cycle();
    cycle();
    drive(1, 0, 1, 1, 0, 32'h500, 4'hF, 32'h0, 32'hCAFEF00D, 1);
    at_neg();
    chk("flush_stallreq", {31'b0, stallreq_o}, 32'h0);
    chk("flush_data", cpu_data_o, 32'h0);
    at_pos();
    drive(1, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 32'hCAFEF00D, 1);
    at_neg();
    chk("flush_cyc", {31'b0, wb_cyc_o}, 32'h0);
    chk("stray_ack_data", cpu_data_o, 32'h0);
    at_pos();
    drive(1, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 0);
    cycle();

    // Reset in the middle of an access.
    drive(1, 0, 0, 1, 1, 32'h600, 4'hC, 32'h55AA55AA, 32'h0, 0);
    cycle();
    cycle();
    drive(0, 0, 0, 1, 1, 32'h600, 4'hC, 32'h55AA55AA, 32'h0, 0);
    at_neg();
    chk("rst_stallreq", {31'b0, stallreq_o}, 32'h0);
    at_pos();
    drive(1, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h11111111, 1);
    at_neg();
    chk("rst_cyc", {31'b0, wb_cyc_o}, 32'h0);
    chk("rst_late_ack_data", cpu_data_o, 32'h0);
    at_pos();
    at_neg();
    chk("rst_late_ack_err", {31'b0, bus_err_o}, 32'h0);
    at_pos();

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      rst        = ($urandom_range(0, 99) >= 2);
      stall_i    = 6'($urandom);
      stall_i[4] = ($urandom_range(0, 99) < 30);
      flush_i    = ($urandom_range(0, 99) < 5);
      cpu_ce_i   = ($urandom_range(0, 99) < 60);
      cpu_we_i   = 1'($urandom);
      cpu_addr_i = $urandom;
      cpu_sel_i  = 4'($urandom);
      cpu_data_i = $urandom;
      wb_dat_i   = $urandom;
      wb_ack_i   = ($urandom_range(0, 99) < 30);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
